// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the store-side lane helpers used by the controller.
package lsu_pkg;

    // Access size encodings as produced by the decoder (funct3[1:0]).
    localparam logic [1:0] LSU_B = 2'b00;
    localparam logic [1:0] LSU_H = 2'b01;
    localparam logic [1:0] LSU_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP,
        DONE
    } lsu_state_e;

    // Misaligned half/word, or the illegal size encoding 2'b11.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LSU_B:   mis = 1'b0;
            LSU_H:   mis = addr_lo[0];
            LSU_W:   mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Byte enables for the addressed lanes; loads and stores share these.
    function automatic logic [3:0] lsu_bmask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            LSU_B:   mask = 4'b0001 << addr_lo;
            LSU_H:   mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Replicate store data across all lanes so the byte enables alone pick
    // the destination bytes.
    function automatic logic [31:0] lsu_wdata(input logic [1:0] size,
                                              input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            LSU_B:   lanes = {4{wdata[7:0]}};
            LSU_H:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the captured
// memory word and sign- or zero-extends it for writeback.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        lsu_signed_i,  // 1 = zero-extend (LBU/LHU)
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by the low address bits.
    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension; the illegal size never reaches writeback, so it returns zero.
    always_comb begin
        data_o = '0;
        case (size_i)
            LSU_B: data_o = lsu_signed_i ? {24'b0, byte_sel}
                                         : {{24{byte_sel[7]}}, byte_sel};
            LSU_H: data_o = lsu_signed_i ? {16'b0, half_sel}
                                         : {{16{half_sel[15]}}, half_sel};
            LSU_W: data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences one data-memory access per
// load/store instruction over a valid/grant/rvalid bus, stalls the core
// until it completes, and aborts accesses that exceed TIMEOUT_CYCLES.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_vld,
    input  logic        i_dmem_we,
    input  logic [1:0]  i_lsu_size,
    input  logic        i_lsu_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_vld,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    // Last cycle allowed in REQ+RSP; reaching it forces DONE.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic        misalign;
    logic        busy;
    logic        timeout;
    logic [31:0] load_data;

    assign misalign = lsu_misaligned(i_lsu_size, i_addr[1:0]);
    assign busy     = (state_q == REQ) || (state_q == RSP);
    // Timeout wins over a grant or rvalid arriving in the same cycle.
    assign timeout  = busy && (cnt_q == CntLast);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_req_vld && !misalign) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (timeout) begin
                    state_d = DONE;
                end else if (i_mem_gnt) begin
                    state_d = i_dmem_we ? DONE : RSP;
                end
            end
            RSP: begin
                if (timeout || i_mem_rvalid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The request still visible here belongs to the finished
                // instruction; never reissue it.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter, load data capture and error flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Datapath next-state: count bus cycles, latch rvalid data in RSP only so
    // stale responses in IDLE/DONE are dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + CntW'(1);
        end

        rdata_d = rdata_q;
        if ((state_q == RSP) && i_mem_rvalid && !timeout) begin
            rdata_d = i_mem_rdata;
        end

        // Set only for the DONE cycle that follows an abort.
        err_d = timeout;
    end

    lsu_load_align u_load_align (
        .rdata_i      (rdata_q),
        .addr_lo_i    (i_addr[1:0]),
        .size_i       (i_lsu_size),
        .lsu_signed_i (i_lsu_signed),
        .data_o       (load_data)
    );

    // Outputs; everything is forced low while reset is held.
    always_comb begin
        o_stall     = 1'b0;
        o_rdata     = '0;
        o_rdata_vld = 1'b0;
        o_misalign  = 1'b0;
        o_bus_err   = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if (!i_reset) begin
            o_stall    = i_req_vld && (state_q != DONE) && !misalign;
            o_misalign = i_req_vld && misalign && (state_q == IDLE);
            if (state_q == REQ) begin
                o_mem_req   = 1'b1;
                o_mem_we    = i_dmem_we;
                o_mem_addr  = {i_addr[31:2], 2'b00};
                o_mem_wdata = lsu_wdata(i_lsu_size, i_wdata);
                o_mem_bmask = lsu_bmask(i_lsu_size, i_addr[1:0]);
            end
            if (state_q == DONE) begin
                o_bus_err   = err_q;
                o_rdata_vld = !i_dmem_we;
                o_rdata     = (!i_dmem_we && !err_q) ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a per-transaction timeline model predicts
// every output on every cycle; literal values pin the model on key cases.
module tb_lsu_ctrl;

    localparam int unsigned T = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_vld;
    logic        i_dmem_we;
    logic [1:0]  i_lsu_size;
    logic        i_lsu_signed;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [31:0] o_rdata;
    logic        o_rdata_vld;
    logic        o_misalign;
    logic        o_bus_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    always #5 i_clk = ~i_clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_vld    (i_req_vld),
        .i_dmem_we    (i_dmem_we),
        .i_lsu_size   (i_lsu_size),
        .i_lsu_signed (i_lsu_signed),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_rdata      (o_rdata),
        .o_rdata_vld  (o_rdata_vld),
        .o_misalign   (o_misalign),
        .o_bus_err    (o_bus_err),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_bmask  (o_mem_bmask),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle.
    logic        exp_en;
    logic        exp_stall, exp_vld, exp_mis, exp_err, exp_req, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_bmask;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Single compare process: every output, every cycle the model is active.
    always @(negedge i_clk) begin
        if (exp_en) begin
            chk("stall",     32'(o_stall),     32'(exp_stall));
            chk("rdata_vld", 32'(o_rdata_vld), 32'(exp_vld));
            chk("rdata",     o_rdata,          exp_rdata);
            chk("misalign",  32'(o_misalign),  32'(exp_mis));
            chk("bus_err",   32'(o_bus_err),   32'(exp_err));
            chk("mem_req",   32'(o_mem_req),   32'(exp_req));
            chk("mem_we",    32'(o_mem_we),    32'(exp_we));
            chk("mem_addr",  o_mem_addr,       exp_addr);
            chk("mem_wdata", o_mem_wdata,      exp_wdata);
            chk("mem_bmask", 32'(o_mem_bmask), 32'(exp_bmask));
        end
    end

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] ad);
        return (sz == 2'd3) || (sz == 2'd1 && (ad % 2) != 0) || (sz == 2'd2 && (ad % 4) != 0);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] m_bmask(input logic [1:0] sz, input logic [31:0] ad);
        int a;
        a = int'(ad % 4);
        if (sz == 2'd0) return 4'(1 << a);
        if (sz == 2'd1) return (a >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] sz,
                                          input logic uns, input logic [31:0] ad);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * (ad % 4))) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (w >> (16 * ((ad % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
            return v;
        end
        return w;
    endfunction

    task automatic clear_exp();
        exp_stall = 0; exp_vld = 0; exp_mis = 0; exp_err = 0; exp_req = 0; exp_we = 0;
        exp_rdata = 0; exp_addr = 0; exp_wdata = 0; exp_bmask = 0;
    endtask

    // One instruction: gnt in cycle g, rvalid in cycle r (0 = never),
    // relative to the request cycle 0. A trailing idle cycle carries a stale rvalid.
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] ad, input logic [31:0] wd,
                           input int g, input int r, input logic [31:0] mw,
                           output int n_stall, output int n_vld, output int n_req,
                           output logic [31:0] got_rdata, output logic [31:0] bus_wdata,
                           output logic [3:0] bus_bmask, output logic [31:0] bus_addr,
                           output logic mis_seen, output logic err_seen);
        logic mis, ok;
        int done, last_req;
        mis = m_mis(sz, ad);
        ok = (g >= 1) && (g <= int'(T) - 1) && (we || (r > g && r <= int'(T) - 1));
        done = mis ? 0 : (ok ? (we ? g + 1 : r + 1) : int'(T) + 1);
        last_req = ok ? g : done - 1;
        n_stall = 0; n_vld = 0; n_req = 0; got_rdata = 0;
        bus_wdata = 0; bus_bmask = 0; bus_addr = 0; mis_seen = 0; err_seen = 0;
        for (int k = 0; k <= done; k++) begin
            i_req_vld = 1; i_dmem_we = we; i_lsu_size = sz; i_lsu_signed = uns;
            i_addr = ad; i_wdata = wd;
            i_mem_gnt = (g > 0 && k == g);
            i_mem_rvalid = (r > 0 && k == r);
            i_mem_rdata = (r > 0 && k == r) ? mw : 32'hDEAD_BEEF;
            clear_exp();
            if (mis) begin
                exp_mis = 1;
            end else if (k < done) begin
                exp_stall = 1;
                if (k >= 1 && k <= last_req) begin
                    exp_req = 1; exp_we = we;
                    exp_addr = ad & 32'hFFFF_FFFC;
                    exp_wdata = m_wdata(sz, wd);
                    exp_bmask = m_bmask(sz, ad);
                end
            end else begin
                exp_err = !ok;
                exp_vld = !we;
                exp_rdata = (!we && ok) ? m_ext(mw, sz, uns, ad) : 32'h0;
            end
            exp_en = 1;
            @(negedge i_clk);
            n_stall += int'(o_stall);
            n_vld += int'(o_rdata_vld);
            n_req += int'(o_mem_req);
            if (o_rdata_vld) got_rdata = o_rdata;
            if (k == 1) begin
                bus_wdata = o_mem_wdata; bus_bmask = o_mem_bmask; bus_addr = o_mem_addr;
            end
            mis_seen |= o_misalign;
            err_seen |= o_bus_err;
            @(posedge i_clk); #1;
        end
        i_req_vld = 0; i_mem_gnt = 0; i_mem_rvalid = 1; i_mem_rdata = 32'hBAD0_BAD0;
        clear_exp();
        @(negedge i_clk);
        @(posedge i_clk); #1;
        i_mem_rvalid = 0;
    endtask

    int ns, nv, nr;
    logic [31:0] rd, bw, ba;
    logic [3:0]  bm;
    logic        ms, es;

    initial begin
        i_reset = 1; i_req_vld = 1; i_dmem_we = 0; i_lsu_size = 2'd2; i_lsu_signed = 0;
        i_addr = 32'h0; i_wdata = 32'h0; i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        clear_exp();
        exp_en = 1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 0; i_req_vld = 0;

        // LB 0x1003 from 0x80FF_1234, gnt +1, rvalid +3.
        run_txn(0, 2'd0, 0, 32'h1003, 0, 1, 3, 32'h80FF_1234, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lb_rdata", rd, 32'hFFFF_FF80);
        chk("lb_stall_cycles", ns, 4);
        // LHU 0x2002 from 0x8001_0000.
        run_txn(0, 2'd1, 1, 32'h2002, 0, 1, 2, 32'h8001_0000, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lhu_rdata", rd, 32'h0000_8001);
        chk("lhu_vld_cycles", nv, 1);
        // SB 0x3001 data 0xAB.
        run_txn(1, 2'd0, 0, 32'h3001, 32'h0000_00AB, 1, 0, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("sb_wdata", bw, 32'hABAB_ABAB);
        chk("sb_bmask", 32'(bm), 32'h2);
        chk("sb_addr", ba, 32'h3000);
        chk("sb_stall_cycles", ns, 2);
        // LW 0x4002: misaligned.
        run_txn(0, 2'd2, 0, 32'h4002, 0, 1, 2, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lw_mis_flag", 32'(ms), 1);
        chk("lw_mis_stall", ns, 0);
        chk("lw_mis_req", nr, 0);
        // Load with gnt withheld: timeout.
        run_txn(0, 2'd2, 0, 32'h5000, 0, 0, 0, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("tmo_err", 32'(es), 1);
        chk("tmo_req_cycles", nr, 4);
        chk("tmo_rdata", rd, 32'h0);

        // Reset during RSP, then a stale rvalid.
        exp_en = 0;
        i_req_vld = 1; i_dmem_we = 0; i_lsu_size = 2'd2; i_addr = 32'hC000;
        @(posedge i_clk); #1;
        i_mem_gnt = 1;
        @(negedge i_clk);
        chk("rst_req_before", 32'(o_mem_req), 1);
        @(posedge i_clk); #1;
        i_mem_gnt = 0; i_reset = 1;
        @(negedge i_clk);
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_stall_req", 32'(o_mem_req), 0);
        @(posedge i_clk); #1;
        i_reset = 0; i_req_vld = 0; i_mem_rvalid = 1; i_mem_rdata = 32'h0BAD_F00D;
        @(negedge i_clk);
        chk("rst_stale_vld", 32'(o_rdata_vld), 0);
        chk("rst_stale_rdata", o_rdata, 0);
        @(posedge i_clk); #1;
        i_mem_rvalid = 0;
        @(negedge i_clk);
        chk("rst_idle_vld", 32'(o_rdata_vld), 0);
        @(posedge i_clk); #1;
        exp_en = 1;

        // LH sign-extend after the reset (shows the FSM is back in IDLE).
        run_txn(0, 2'd1, 0, 32'h6000, 0, 2, 3, 32'h1234_F00D, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lh_rdata", rd, 32'hFFFF_F00D);
        // SH upper half.
        run_txn(1, 2'd1, 0, 32'h7002, 32'h1234_BEEF, 1, 0, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("sh_wdata", bw, 32'hBEEF_BEEF);
        chk("sh_bmask", 32'(bm), 32'hC);
        // SW with gnt in the last allowed cycle.
        run_txn(1, 2'd2, 0, 32'h8004, 32'hCAFE_F00D, 3, 0, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("sw_err", 32'(es), 0);
        chk("sw_stall_cycles", ns, 4);
        // Store with gnt coinciding with timeout.
        run_txn(1, 2'd2, 0, 32'h8008, 32'h1111_2222, 4, 0, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("st_tmo_err", 32'(es), 1);
        // Illegal size and misaligned half.
        run_txn(0, 2'd3, 0, 32'h9000, 0, 1, 2, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("sz11_mis", 32'(ms), 1);
        run_txn(0, 2'd1, 0, 32'hB001, 0, 1, 2, 0, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lh_mis", 32'(ms), 1);
        // LBU lane 2 and an aligned LW.
        run_txn(0, 2'd0, 1, 32'h9002, 0, 1, 2, 32'h00A5_0000, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lbu_rdata", rd, 32'h0000_00A5);
        run_txn(0, 2'd2, 0, 32'hA000, 0, 1, 2, 32'h1357_9BDF, ns, nv, nr, rd, bw, bm, ba, ms, es);
        chk("lw_rdata", rd, 32'h1357_9BDF);

        exp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit for the single-cycle RV32I core: consumes the decoder's memory-control outputs (write enable, size, extension select) plus the ALU address and rs2 data. It drives a valid/grant/rvalid data-memory bus with variable latency, stalls the core until the access completes, and returns byte-lane-extracted, sign- or zero-extended load data to writeback. It checks alignment and bounds each access with a timeout.

## Interface
- TIMEOUT_CYCLES, default 255: maximum cycles allowed in REQ+RSP before the access is aborted.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_vld  in  1  current instruction is a load or store.
- i_dmem_we  in  1  1 = store, 0 = load.
- i_lsu_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- i_lsu_signed  in  1  carries funct3[2]: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- i_addr  in  32  byte address from the ALU.
- i_wdata  in  32  rs2 store data.
- o_stall  out  1  hold PC and instruction this cycle.
- o_rdata  out  32  extended load data; valid when o_rdata_vld.
- o_rdata_vld  out  1  load result valid (DONE cycle of a load).
- o_misalign  out  1  misaligned or illegal-size access this cycle.
- o_bus_err  out  1  one-cycle pulse: access timed out.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write.
- o_mem_addr  out  32  {i_addr[31:2],2'b00}.
- o_mem_wdata  out  32  lane-replicated store data.
- o_mem_bmask  out  4  byte enables.
- i_mem_gnt  in  1  request accepted this cycle.
- i_mem_rvalid  in  1  load data valid. Never asserted in the same cycle as the matching gnt.
- i_mem_rdata  in  32  raw load word.

## Operation
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - Aligned request: go to REQ; o_stall=1.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or size 11): no bus activity; o_misalign=1, o_stall=0, o_rdata=0; stay in IDLE.
- REQ:
  - o_mem_req=1; address, we, wdata and bmask are held from the inputs, which the core keeps stable while stalled.
  - On i_mem_gnt: a store goes to DONE, a load goes to RSP.
- RSP: on i_mem_rvalid, capture i_mem_rdata into rdata_q and go to DONE.
- DONE: o_stall=0. For a load, o_rdata_vld=1. Always go to IDLE next cycle.
- Timeout counter:
  - Cleared in IDLE; increments in REQ and RSP.
  - When it reaches TIMEOUT_CYCLES: go to DONE with o_bus_err=1, o_rdata=0, and drop o_mem_req.
- o_stall = i_req_vld & (state≠DONE) & ~misalign.
- Store lanes:
  - Byte: wdata={4{i_wdata[7:0]}}, bmask=4'b0001<<addr[1:0].
  - Half: wdata={2{i_wdata[15:0]}}, bmask= addr[1] ? 1100 : 0011.
  - Word: bmask=1111.
- Loads use the same bmask.
- Load extraction:
  - Select the byte/half from rdata_q by addr[1:0].
  - Extend per i_lsu_signed.
  - Word loads pass the word through unchanged.
- An rvalid arriving in IDLE or DONE (stale) is ignored.

## Timing
- Reset values:
  - state=IDLE, counter=0, rdata_q=0.
  - While i_reset is high, every output is 0.
- Minimum latencies (request cycle = cycle 0):
  - Store with gnt in cycle 1: DONE in cycle 2, 3 cycles total.
  - Load with gnt in cycle 1 and rvalid in cycle 2: DONE in cycle 3.
- A request present in the DONE cycle belongs to the finished instruction and is not reissued. The next instruction's request is seen in IDLE.
- Reset during REQ/RSP abandons the access; any later rvalid is ignored.
- Counter width: $clog2(TIMEOUT_CYCLES+1). Timeout has priority over a simultaneous gnt or rvalid.

## Structure
- Package lsu_pkg holds:
  - Size constants LSU_B=2'b00, LSU_H=2'b01, LSU_W=2'b10.
  - The state enum lsu_state_e {IDLE, REQ, RSP, DONE}.
- One sub-module, lsu_load_align: combinational extraction and extension. Inputs: rdata_q, addr[1:0], size, signed.

## Test plan
- LB, addr 0x1003, mem word 0x80FF_1234, gnt at +1, rvalid at +3 → o_rdata=0xFFFF_FF80 in DONE; o_stall high for 4 cycles.
- LHU, addr 0x2002, word 0x8001_0000 → o_rdata=0x0000_8001, o_rdata_vld one cycle.
- SB, addr 0x3001, wdata 0xAB → o_mem_wdata=0xABAB_ABAB, bmask=0010, addr=0x3000; DONE the cycle after gnt.
- LW, addr 0x4002 → o_misalign=1, o_stall=0, o_mem_req stays 0.
- Load with gnt withheld, TIMEOUT_CYCLES=4 → o_bus_err pulse after 4 REQ cycles, o_rdata=0, back to IDLE.
- i_reset asserted in RSP, stale rvalid one cycle later → state IDLE, no o_rdata_vld.
